// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 3;
   localparam int DEF_NRD    = 2;

   // Widest dirty vector the popcount helper accepts (ADDR_W up to 8).
   localparam int POP_MAX = 256;

   function automatic int unsigned popcount(input logic [POP_MAX-1:0] vec);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_MAX; i++) begin
         n += {31'b0, vec[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/regfile_dec.sv
// One-hot write-enable decoder: bit addr of onehot is set when en is high.
module regfile_dec
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0]      addr,
   input  logic                   en,
   output logic [2**ADDR_W-1:0]   onehot
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register dirty tracking, synchronous clear
// and optionally registered read ports that bypass same-edge writes and clears.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NRD    = DEF_NRD,
   parameter int REG_RD = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_W-1:0]      data_in,
   input  logic [ADDR_W-1:0]      writenum,
   input  logic                   write,
   input  logic                   clear,
   input  logic [NRD*ADDR_W-1:0]  readnum,
   output logic [NRD*DATA_W-1:0]  data_out,
   output logic [2**ADDR_W-1:0]   dirty,
   output logic [ADDR_W:0]        wr_count
);

   localparam int NREGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  we;
   logic [NREGS-1:0]  dirty_q;

   regfile_dec #(.ADDR_W(ADDR_W)) u_dec (
      .addr   (writenum),
      .en     (write),
      .onehot (we)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the storage array is reset element by element because every register must read 0 after reset; this keeps it in flops rather than a RAM macro.
         for (int k = 0; k < NREGS; k++) regs[k] <= '0;
         dirty_q <= '0;
      end else if (clear) begin
         for (int k = 0; k < NREGS; k++) regs[k] <= '0;
         dirty_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         for (int k = 0; k < NREGS; k++) begin
            if (we[k]) regs[k] <= data_in;
         end
         dirty_q <= dirty_q | we;
      end
   end

   assign dirty    = dirty_q;
   assign wr_count = (ADDR_W+1)'(popcount(POP_MAX'(dirty_q)));

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] cur;

      assign ra  = readnum[i*ADDR_W +: ADDR_W];
      assign cur = regs[ra];

      if (REG_RD != 0) begin : g_reg
         logic [DATA_W-1:0] nxt;
         logic [DATA_W-1:0] q;

         // Capture what the addressed register will hold after this edge.
         always_comb begin
            nxt = cur;
            if (clear)       nxt = '0;
            else if (we[ra]) nxt = data_in;
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) q <= '0;
            else       q <= nxt;
         end

         assign data_out[i*DATA_W +: DATA_W] = q;
      end else begin : g_comb
         assign data_out[i*DATA_W +: DATA_W] = cur;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: three regfile_mp configurations driven in lockstep and
// compared against an array-based reference model of the register file.
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic        wr;
   logic        clr;
   logic [3:0]  wn;
   logic [31:0] din;
   logic [3:0]  rn [3];

   logic [31:0] dout0, dout1;
   logic [95:0] dout2;
   logic [7:0]  dirty0, dirty1;
   logic [15:0] dirty2;
   logic [3:0]  cnt0, cnt1;
   logic [4:0]  cnt2;

   int tests = 0;
   int fails = 0;

   // Reference model, indexed by configuration: 0 = registered reads,
   // 1 = combinational reads, 2 = wide registered (32-bit, 16 regs, 3 ports).
   logic [31:0] m_reg   [3][16];
   logic        m_dirty [3][16];
   logic [31:0] m_q     [3][3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(2), .REG_RD(1)) dut0 (
      .clk(clk), .reset(rst), .data_in(din[15:0]), .writenum(wn[2:0]),
      .write(wr), .clear(clr), .readnum({rn[1][2:0], rn[0][2:0]}),
      .data_out(dout0), .dirty(dirty0), .wr_count(cnt0)
   );

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(2), .REG_RD(0)) dut1 (
      .clk(clk), .reset(rst), .data_in(din[15:0]), .writenum(wn[2:0]),
      .write(wr), .clear(clr), .readnum({rn[1][2:0], rn[0][2:0]}),
      .data_out(dout1), .dirty(dirty1), .wr_count(cnt1)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(4), .NRD(3), .REG_RD(1)) dut2 (
      .clk(clk), .reset(rst), .data_in(din), .writenum(wn),
      .write(wr), .clear(clr), .readnum({rn[2], rn[1], rn[0]}),
      .data_out(dout2), .dirty(dirty2), .wr_count(cnt2)
   );

   function automatic int aw(int d);  return (d == 2) ? 4 : 3;  endfunction
   function automatic int dw(int d);  return (d == 2) ? 32 : 16; endfunction
   function automatic int nrd(int d); return (d == 2) ? 3 : 2;  endfunction

   function automatic void model_reset();
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 16; k++) begin
            m_reg[d][k]   = '0;
            m_dirty[d][k] = 1'b0;
         end
         for (int p = 0; p < 3; p++) m_q[d][p] = '0;
      end
   endfunction

   // Apply one rising edge to the model using the currently driven inputs.
   function automatic void model_edge();
      int am;
      logic [31:0] dm;
      for (int d = 0; d < 3; d++) begin
         am = (1 << aw(d)) - 1;
         dm = (dw(d) == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
         if (clr) begin
            for (int k = 0; k < 16; k++) begin
               m_reg[d][k]   = '0;
               m_dirty[d][k] = 1'b0;
            end
         end else if (wr) begin
            m_reg[d][int'(wn) & am]   = din & dm;
            m_dirty[d][int'(wn) & am] = 1'b1;
         end
         for (int p = 0; p < nrd(d); p++) m_q[d][p] = m_reg[d][int'(rn[p]) & am];
      end
   endfunction

   function automatic logic [95:0] exp_out(int d);
      logic [95:0] r;
      logic [31:0] v;
      int am;
      r  = '0;
      am = (1 << aw(d)) - 1;
      for (int p = 0; p < nrd(d); p++) begin
         v = (d == 1) ? m_reg[d][int'(rn[p]) & am] : m_q[d][p];
         r = r | ({64'b0, v} << (p * dw(d)));
      end
      return r;
   endfunction

   function automatic logic [15:0] exp_dirty(int d);
      logic [15:0] r;
      r = '0;
      for (int k = 0; k < (1 << aw(d)); k++) r[k] = m_dirty[d][k];
      return r;
   endfunction

   function automatic int exp_cnt(int d);
      int n;
      n = 0;
      for (int k = 0; k < 16; k++) if (m_dirty[d][k]) n++;
      return n;
   endfunction

   function automatic logic [95:0] act_out(int d);
      case (d)
         0:       return {64'b0, dout0};
         1:       return {64'b0, dout1};
         default: return dout2;
      endcase
   endfunction

   function automatic logic [15:0] act_dirty(int d);
      case (d)
         0:       return {8'b0, dirty0};
         1:       return {8'b0, dirty1};
         default: return dirty2;
      endcase
   endfunction

   function automatic int act_cnt(int d);
      case (d)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   task automatic drive(input logic w, input logic c, input logic [3:0] a,
                        input logic [31:0] v, input logic [3:0] r0,
                        input logic [3:0] r1, input logic [3:0] r2);
      wr = w; clr = c; wn = a; din = v;
      rn[0] = r0; rn[1] = r1; rn[2] = r2;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd1, 4'd2);
      model_reset();
      #2;
      for (int d = 0; d < 3; d++) begin
         tests++;
         if (act_out(d) !== exp_out(d)) begin
            fails++; $display("FAIL reset_dout dut%0d got %h exp %h", d, act_out(d), exp_out(d));
         end
         tests++;
         if (act_dirty(d) !== 16'd0 || act_cnt(d) !== 0) begin
            fails++; $display("FAIL reset_dirty dut%0d dirty %h cnt %0d exp 0/0", d, act_dirty(d), act_cnt(d));
         end
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_write_read();
      drive(1'b1, 1'b0, 4'd3, 32'h0000_ABCD, 4'd3, 4'd3, 4'd3);
      tick();
      drive(1'b0, 1'b0, 4'd3, 32'h0000_FFFF, 4'd3, 4'd3, 4'd3);
      tick();
      tests++;
      if (dout0 !== 32'hABCD_ABCD || dout1 !== 32'hABCD_ABCD) begin
         fails++; $display("FAIL write_read_dout got %h/%h exp abcdabcd", dout0, dout1);
      end
      tests++;
      if (dout2 !== {3{32'h0000_ABCD}}) begin
         fails++; $display("FAIL write_read_wide got %h exp %h", dout2, {3{32'h0000_ABCD}});
      end
      tests++;
      if (dirty0 !== 8'b0000_1000 || dirty1 !== 8'b0000_1000 || dirty2 !== 16'h0008) begin
         fails++; $display("FAIL write_read_dirty got %h/%h/%h exp 08", dirty0, dirty1, dirty2);
      end
      tests++;
      if (cnt0 !== 4'd1 || cnt1 !== 4'd1 || cnt2 !== 5'd1) begin
         fails++; $display("FAIL write_read_count got %0d/%0d/%0d exp 1", cnt0, cnt1, cnt2);
      end
   endtask

   task automatic test_write_disabled();
      drive(1'b0, 1'b0, 4'd3, 32'hFFFF_FFFF, 4'd3, 4'd0, 4'd3);
      tick();
      tests++;
      if (dout0[15:0] !== 16'hABCD || dout1[15:0] !== 16'hABCD || cnt0 !== 4'd1) begin
         fails++; $display("FAIL write_disabled got %h/%h cnt %0d exp abcd cnt 1", dout0[15:0], dout1[15:0], cnt0);
      end
      for (int d = 0; d < 3; d++) begin
         tests++;
         if (act_out(d) !== exp_out(d)) begin
            fails++; $display("FAIL write_disabled_model dut%0d got %h exp %h", d, act_out(d), exp_out(d));
         end
      end
   endtask

   task automatic test_bypass();
      drive(1'b1, 1'b0, 4'd5, 32'h0000_1234, 4'd5, 4'd3, 4'd5);
      tick();
      tests++;
      if (dout0[15:0] !== 16'h1234 || dout2[31:0] !== 32'h0000_1234) begin
         fails++; $display("FAIL bypass got %h/%h exp 1234", dout0[15:0], dout2[31:0]);
      end
      tests++;
      if (dout0[31:16] !== 16'hABCD || cnt0 !== 4'd2) begin
         fails++; $display("FAIL bypass_other got %h cnt %0d exp abcd cnt 2", dout0[31:16], cnt0);
      end
   endtask

   task automatic test_fill_clear();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 1'b0, 4'(k), 32'h0101 * k, 4'(k), 4'(k), 4'(k));
         tick();
      end
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b0, 4'd0, 32'd0, 4'(k), 4'(7 - k), 4'(k + 3));
         tick();
         for (int d = 0; d < 3; d++) begin
            tests++;
            if (act_out(d) !== exp_out(d)) begin
               fails++; $display("FAIL fill_read k%0d dut%0d got %h exp %h", k, d, act_out(d), exp_out(d));
            end
         end
      end
      tests++;
      if (cnt0 !== 4'd8 || cnt1 !== 4'd8 || cnt2 !== 5'd8) begin
         fails++; $display("FAIL fill_count got %0d/%0d/%0d exp 8", cnt0, cnt1, cnt2);
      end
      drive(1'b1, 1'b1, 4'd2, 32'hDEAD_BEEF, 4'd2, 4'd7, 4'd2);
      tick();
      tests++;
      if (dout0 !== 32'd0 || dout1 !== 32'd0 || dout2 !== 96'd0) begin
         fails++; $display("FAIL clear_dout got %h/%h/%h exp 0", dout0, dout1, dout2);
      end
      tests++;
      if (dirty0 !== 8'd0 || dirty2 !== 16'd0 || cnt0 !== 4'd0 || cnt2 !== 5'd0) begin
         fails++; $display("FAIL clear_dirty got %h/%h cnt %0d/%0d exp 0", dirty0, dirty2, cnt0, cnt2);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 1'b0, 4'd7, 32'h0000_00FF, 4'd7, 4'd7, 4'd7);
      tick();
      tests++;
      if (dout0 !== 32'h00FF_00FF || cnt0 !== 4'd1) begin
         fails++; $display("FAIL preload got %h cnt %0d exp 00ff00ff cnt 1", dout0, cnt0);
      end
      #3;
      drive(1'b1, 1'b0, 4'd7, 32'h0000_FFFF, 4'd7, 4'd7, 4'd7);
      rst = 1'b1;
      model_reset();
      #1;
      tests++;
      if (dout0 !== 32'd0 || dout1 !== 32'd0 || dout2 !== 96'd0) begin
         fails++; $display("FAIL async_reset_dout got %h/%h/%h exp 0", dout0, dout1, dout2);
      end
      tests++;
      if (cnt0 !== 4'd0 || cnt1 !== 4'd0 || cnt2 !== 5'd0) begin
         fails++; $display("FAIL async_reset_count got %0d/%0d/%0d exp 0", cnt0, cnt1, cnt2);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 1'b0, 4'd7, 32'h4242_4242, 4'd7, 4'd7, 4'd7);
      #1;
      tests++;
      if (dout1 !== 32'd0 || dirty1 !== 8'd0) begin
         fails++; $display("FAIL reset_discard got %h dirty %h exp 0", dout1, dirty1);
      end
      tick();
      tests++;
      if (dout0 !== 32'h4242_4242 || dout2 !== {3{32'h4242_4242}} || cnt0 !== 4'd1) begin
         fails++; $display("FAIL first_write got %h/%h cnt %0d exp 42424242 cnt 1", dout0, dout2, cnt0);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0),
               4'($urandom_range(0, 15)), $urandom,
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)));
         if (n % 7 == 0) rn[1] = rn[0];
         tick();
         for (int d = 0; d < 3; d++) begin
            tests++;
            if (act_out(d) !== exp_out(d)) begin
               fails++; $display("FAIL random_dout n%0d dut%0d got %h exp %h", n, d, act_out(d), exp_out(d));
            end
            tests++;
            if (act_dirty(d) !== exp_dirty(d) || act_cnt(d) !== exp_cnt(d)) begin
               fails++; $display("FAIL random_dirty n%0d dut%0d got %h/%0d exp %h/%0d",
                                 n, d, act_dirty(d), act_cnt(d), exp_dirty(d), exp_cnt(d));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_write_disabled();
      test_bypass();
      test_fill_clear();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
